// File: rtl/ddr_rx_pkg.sv
// Shared types and helpers for the DDR receive deserializer.
// State encoding, sync alignment codes and counter sizing.
package ddr_rx_pkg;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   typedef logic align_t;
   localparam align_t ALIGN_RISE = 1'b0;
   localparam align_t ALIGN_FALL = 1'b1;

   // Room for the count to reach WORD_W+1 so a two-bit step never wraps.
   function automatic int cnt_width(input int word_w);
      return $clog2(word_w + 2);
   endfunction

endpackage

// File: rtl/ddr_rx_deserializer_if.sv
// Receive-path bundle: bit-pair input side and word output handshake.
// master drives bit pairs and ready; slave is the deserializer.
interface ddr_rx_deserializer_if #(
   parameter int WORD_W = 8
);
   logic              din_rise;
   logic              din_fall;
   logic              din_en;
   logic              resync;
   logic [WORD_W-1:0] dout;
   logic              dout_valid;
   logic              dout_ready;
   logic              locked;
   logic              overflow;

   modport master (
      output din_rise, din_fall, din_en, resync, dout_ready,
      input  dout, dout_valid, locked, overflow
   );

   modport slave (
      input  din_rise, din_fall, din_en, resync, dout_ready,
      output dout, dout_valid, locked, overflow
   );
endinterface

// File: rtl/ddr_rx_word_fifo.sv
// Fall-through word FIFO: a push is visible at head one cycle later.
// Push on full is accepted only alongside a pop; otherwise the caller sees full.
module ddr_rx_word_fifo #(
   parameter int WORD_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [WORD_W-1:0] push_data,
   input  logic              pop,
   output logic [WORD_W-1:0] head,
   output logic              full,
   output logic              empty
);
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [WORD_W-1:0] mem [FIFO_DEPTH];
   logic [AW:0]       wptr;
   logic [AW:0]       rptr;
   logic              do_push;
   logic              do_pop;

   assign empty   = (wptr == rptr);
   assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr <= '0;
         rptr <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         // On full+pop the write slot is the head being popped, so it is free.
         if (do_push) begin
            mem[wptr[AW-1:0]] <= push_data;
            wptr              <= wptr + {{AW{1'b0}}, 1'b1};
         end
         if (do_pop) rptr <= rptr + {{AW{1'b0}}, 1'b1};
      end
   end
endmodule

// File: rtl/ddr_rx_deserializer.sv
// Hunts for the sync pattern in the rise/fall pair stream, then packs MSB-first words into a FIFO.
// Word visible one cycle after its final pair; a push into a full FIFO without a pop is dropped and flagged.
module ddr_rx_deserializer
   import ddr_rx_pkg::*;
#(
   parameter int                WORD_W     = 8,
   parameter int                SYNC_W     = 8,
   parameter logic [SYNC_W-1:0] SYNC_PAT   = 8'hD5,
   parameter int                FIFO_DEPTH = 4
) (
   input logic                   clk,
   input logic                   reset,
   ddr_rx_deserializer_if.slave  bus
);
   localparam int CW = cnt_width(WORD_W);
   localparam logic [CW-1:0] LAST_RISE = CW'(WORD_W - 1);
   localparam logic [CW-1:0] LAST_FALL = CW'(WORD_W - 2);

   state_t            state;
   logic [SYNC_W-1:0] hist;
   logic [WORD_W-1:0] word;
   logic [CW-1:0]     cnt;
   logic              locked_r;
   logic              ovf_r;

   logic [SYNC_W-1:0] hist_a;
   logic [SYNC_W-1:0] hist_b;
   logic              match_a;
   logic              match_b;
   align_t            align;
   logic [WORD_W-1:0] word_a;
   logic [WORD_W-1:0] word_b;
   logic              push;
   logic [WORD_W-1:0] push_word;
   logic              pop;
   logic              full;
   logic              empty;

   always_comb begin
      hist_a    = {hist[SYNC_W-2:0], bus.din_rise};
      hist_b    = {hist_a[SYNC_W-2:0], bus.din_fall};
      match_a   = (hist_a == SYNC_PAT);
      match_b   = (hist_b == SYNC_PAT);
      align     = match_a ? ALIGN_RISE : ALIGN_FALL;
      word_a    = {word[WORD_W-2:0], bus.din_rise};
      word_b    = {word_a[WORD_W-2:0], bus.din_fall};
      push      = 1'b0;
      push_word = word_b;
      // resync discards any word that would complete in the same cycle.
      if (state == LOCKED && bus.din_en && !bus.resync) begin
         if (cnt == LAST_RISE) begin
            push      = 1'b1;
            push_word = word_a;
         end else if (cnt == LAST_FALL) begin
            push      = 1'b1;
         end
      end
   end

   assign pop = ~empty & bus.dout_ready;

   always_ff @(posedge clk) begin
      if (reset || bus.resync) begin
         state    <= HUNT;
         hist     <= '0;
         word     <= '0;
         cnt      <= '0;
         locked_r <= 1'b0;
         ovf_r    <= 1'b0;
      end else begin
         if (push && full && !pop) ovf_r <= 1'b1;
         if (bus.din_en) begin
            case (state)
               HUNT: begin
                  hist <= hist_b;
                  if (match_a || match_b) begin
                     state    <= LOCKED;
                     locked_r <= 1'b1;
                     // A rise-bit match leaves the fall bit as the first data bit.
                     if (align == ALIGN_RISE) begin
                        word <= {{(WORD_W-1){1'b0}}, bus.din_fall};
                        cnt  <= CW'(1);
                     end else begin
                        word <= '0;
                        cnt  <= '0;
                     end
                  end
               end
               LOCKED: begin
                  word <= word_b;
                  if (cnt == LAST_RISE)      cnt <= CW'(1);
                  else if (cnt == LAST_FALL) cnt <= '0;
                  else                       cnt <= cnt + CW'(2);
               end
               default: state <= HUNT;
            endcase
         end
      end
   end

   ddr_rx_word_fifo #(
      .WORD_W     (WORD_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_word),
      .pop       (pop),
      .head      (bus.dout),
      .full      (full),
      .empty     (empty)
   );

   assign bus.dout_valid = ~empty;
   assign bus.locked     = locked_r;
   assign bus.overflow   = ovf_r;
endmodule

// File: tb/tb_ddr_rx_deserializer.sv
// Bench for ddr_rx_deserializer: directed scenarios plus random traffic against a bit-serial model.
module tb_ddr_rx_deserializer;
   localparam int         WORD_W = 8;
   localparam int         DEPTH  = 4;
   localparam logic [7:0] SYNC   = 8'hD5;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   ddr_rx_deserializer_if #(.WORD_W(WORD_W)) bus ();

   ddr_rx_deserializer #(
      .WORD_W     (WORD_W),
      .SYNC_W     (8),
      .SYNC_PAT   (SYNC),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: the stream is consumed one bit at a time.
   bit         m_locked;
   logic [7:0] m_hist;
   int         m_nbits;
   logic [7:0] m_word;
   bit         m_ovf;
   logic [7:0] q[$];

   function automatic void m_reset();
      m_locked = 0;
      m_hist   = '0;
      m_nbits  = 0;
      m_word   = '0;
      m_ovf    = 0;
      q.delete();
   endfunction

   function automatic void m_bit(input logic b, inout bit got, inout logic [7:0] w);
      if (!m_locked) begin
         m_hist = {m_hist[6:0], b};
         if (m_hist == SYNC) begin
            m_locked = 1;
            m_nbits  = 0;
         end
      end else begin
         m_word = {m_word[6:0], b};
         m_nbits++;
         if (m_nbits == WORD_W) begin
            got     = 1;
            w       = m_word;
            m_nbits = 0;
         end
      end
   endfunction

   task automatic cycle(input logic r, input logic f, input logic en, input logic rs, input logic rdy);
      bit         got = 0;
      bit         pop;
      logic [7:0] w   = '0;
      bus.din_rise   = r;
      bus.din_fall   = f;
      bus.din_en     = en;
      bus.resync     = rs;
      bus.dout_ready = rdy;
      pop = rdy && (q.size() > 0);
      if (rs) begin
         m_locked = 0;
         m_hist   = '0;
         m_nbits  = 0;
         m_word   = '0;
         m_ovf    = 0;
      end else if (en) begin
         m_bit(r, got, w);
         m_bit(f, got, w);
      end
      if (pop) void'(q.pop_front());
      if (got) begin
         if (q.size() < DEPTH) q.push_back(w);
         else m_ovf = 1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic rdy);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, rdy);
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap, input logic rdy_last);
      for (int i = 0; i < 4; i++) begin
         cycle(b[7-2*i], b[6-2*i], 1'b1, 1'b0, (i == 3) ? rdy_last : 1'b0);
         repeat (gap) idle(1'b0);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.din_rise = 0; bus.din_fall = 0; bus.din_en = 0; bus.resync = 0; bus.dout_ready = 0;
      repeat (5) @(posedge clk);
      #1;
      reset = 1'b0;
      m_reset();
      checks++; if (bus.locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%0b exp=0", bus.locked); end
      checks++; if (bus.dout_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", bus.dout_valid); end
      checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0b exp=0", bus.overflow); end
      checks++; if (bus.dout !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h exp=00", bus.dout); end
   endtask

   task automatic test_align_b();
      send_byte(8'hD5, 0, 1'b0);
      checks++; if (bus.locked !== 1'b1) begin failures++; $display("FAIL alignb_locked got=%0b exp=1", bus.locked); end
      checks++; if (bus.dout_valid !== 1'b0) begin failures++; $display("FAIL alignb_early_valid got=%0b exp=0", bus.dout_valid); end
      send_byte(8'hA3, 0, 1'b0);
      checks++; if (bus.dout_valid !== 1'b1) begin failures++; $display("FAIL alignb_valid got=%0b exp=1", bus.dout_valid); end
      checks++; if (bus.dout !== 8'hA3) begin failures++; $display("FAIL alignb_dout got=%h exp=a3", bus.dout); end
      idle(1'b1);
      checks++; if (bus.dout_valid !== 1'b0) begin failures++; $display("FAIL alignb_popped got=%0b exp=0", bus.dout_valid); end
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      checks++; if (bus.locked !== 1'b0) begin failures++; $display("FAIL alignb_resync got=%0b exp=0", bus.locked); end
   endtask

   task automatic test_align_a();
      logic [1:0] pa [9];
      pa = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b11, 2'b10, 2'b00};
      for (int i = 0; i < 9; i++) begin
         cycle(pa[i][1], pa[i][0], 1'b1, 1'b0, 1'b0);
         if (i == 3) begin
            checks++; if (bus.locked !== 1'b0) begin failures++; $display("FAIL aligna_prelock got=%0b exp=0", bus.locked); end
         end
         if (i == 4) begin
            checks++; if (bus.locked !== 1'b1) begin failures++; $display("FAIL aligna_locked got=%0b exp=1", bus.locked); end
         end
      end
      checks++; if (bus.dout_valid !== 1'b1) begin failures++; $display("FAIL aligna_valid got=%0b exp=1", bus.dout_valid); end
      checks++; if (bus.dout !== 8'h3C) begin failures++; $display("FAIL aligna_dout got=%h exp=3c", bus.dout); end
      idle(1'b1);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_overflow();
      logic [7:0] exp;
      send_byte(8'hD5, 0, 1'b0);
      for (int k = 1; k <= 5; k++) send_byte(8'(k), 0, 1'b0);
      checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%0b exp=1", bus.overflow); end
      for (int k = 1; k <= 4; k++) begin
         exp = 8'(k);
         checks++; if (bus.dout_valid !== 1'b1 || bus.dout !== exp) begin failures++; $display("FAIL ovf_pop got=%0b/%h exp=1/%h", bus.dout_valid, bus.dout, exp); end
         idle(1'b1);
      end
      checks++; if (bus.dout_valid !== 1'b0) begin failures++; $display("FAIL ovf_drained got=%0b exp=0", bus.dout_valid); end
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL ovf_cleared got=%0b exp=0", bus.overflow); end
      send_byte(8'hD5, 0, 1'b0);
      for (int k = 0; k < 4; k++) send_byte(8'h11 + 8'(k), 0, 1'b0);
      send_byte(8'h15, 0, 1'b1);
      checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL full_pop_nodrop got=%0b exp=0", bus.overflow); end
      for (int k = 0; k < 4; k++) begin
         exp = 8'h12 + 8'(k);
         checks++; if (bus.dout_valid !== 1'b1 || bus.dout !== exp) begin failures++; $display("FAIL full_pop_order got=%0b/%h exp=1/%h", bus.dout_valid, bus.dout, exp); end
         idle(1'b1);
      end
      checks++; if (bus.dout_valid !== 1'b0) begin failures++; $display("FAIL full_pop_drained got=%0b exp=0", bus.dout_valid); end
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_din_en_gaps();
      send_byte(8'hD5, 3, 1'b0);
      checks++; if (bus.locked !== 1'b1) begin failures++; $display("FAIL gaps_locked got=%0b exp=1", bus.locked); end
      send_byte(8'hA3, 3, 1'b0);
      checks++; if (bus.dout_valid !== 1'b1 || bus.dout !== 8'hA3) begin failures++; $display("FAIL gaps_dout got=%0b/%h exp=1/a3", bus.dout_valid, bus.dout); end
      idle(1'b1);
      checks++; if (bus.dout_valid !== 1'b0) begin failures++; $display("FAIL gaps_spurious got=%0b exp=0", bus.dout_valid); end
   endtask

   task automatic test_resync();
      logic [7:0] exp;
      for (int k = 0; k < 5; k++) send_byte(8'h71 + 8'(k), 0, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      checks++; if (bus.locked !== 1'b0) begin failures++; $display("FAIL resync_locked got=%0b exp=0", bus.locked); end
      checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL resync_ovf got=%0b exp=0", bus.overflow); end
      for (int k = 0; k < 4; k++) begin
         exp = 8'h71 + 8'(k);
         checks++; if (bus.dout_valid !== 1'b1 || bus.dout !== exp) begin failures++; $display("FAIL resync_retained got=%0b/%h exp=1/%h", bus.dout_valid, bus.dout, exp); end
         idle(1'b1);
      end
      send_byte(8'hD5, 0, 1'b0);
      send_byte(8'h5A, 0, 1'b0);
      checks++; if (bus.dout_valid !== 1'b1 || bus.dout !== 8'h5A) begin failures++; $display("FAIL resync_relock got=%0b/%h exp=1/5a", bus.dout_valid, bus.dout); end
      idle(1'b1);
   endtask

   task automatic test_random();
      int bad = 0;
      for (int n = 0; n < 3000; n++) begin
         cycle(1'($urandom % 2), 1'($urandom % 2), ($urandom % 4) != 0,
               ($urandom % 100) == 0, 1'($urandom % 2));
         checks++;
         if (bus.locked !== m_locked || bus.dout_valid !== (q.size() > 0) || bus.overflow !== m_ovf ||
             (q.size() > 0 && bus.dout !== q[0])) begin
            failures++;
            if (bad < 10) $display("FAIL random_cycle%0d got=%0b/%0b/%0b/%h exp=%0b/%0b/%0b/%h", n,
               bus.locked, bus.dout_valid, bus.overflow, bus.dout,
               m_locked, q.size() > 0, m_ovf, (q.size() > 0) ? q[0] : 8'h00);
            bad++;
         end
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      m_reset();
      checks++; if (bus.dout_valid !== 1'b0 || bus.locked !== 1'b0 || bus.overflow !== 1'b0 || bus.dout !== 8'h00) begin
         failures++; $display("FAIL midframe_reset got=%0b/%0b/%0b/%h exp=0/0/0/00", bus.dout_valid, bus.locked, bus.overflow, bus.dout);
      end
   endtask

   initial begin
      test_reset();
      test_align_b();
      test_align_a();
      test_overflow();
      test_din_en_gaps();
      test_resync();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
